prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_W, 16, instruction word width in bits (multiple of 8; only 16 is required).
REQ-002 SHALL have parameter ADDR_W, 8, instruction memory address width; capacity is 2^ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  serial program byte.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-008 SHALL have port mem_we  output  1  one-cycle write strobe to instruction RAM.
REQ-009 SHALL have port mem_addr  output  ADDR_W  write word address.
REQ-010 SHALL have port mem_wdata  output  DATA_W  write word.
REQ-011 SHALL have port cpu_rst  output  1  active-high reset to the CPU.
REQ-012 SHALL have port done  output  1  load completed successfully (sticky).
REQ-013 SHALL have port error  output  1  load aborted (sticky).

Function
REQ-014 Stream format SHALL be: 16-bit word count N (high byte first), then N words (high byte first), then one checksum byte only when PROG_LOADER_CHECKSUM_EN is defined.
REQ-015 FSM states SHALL be LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR; each receive state advances only on a transfer.
REQ-016 LEN_LO SHALL go to ERROR if N > 2^ADDR_W, to CHK (macro on) or DONE (macro off) if N = 0, else to DATA_HI.
REQ-017 DATA_LO transfer SHALL go to WRITE; WRITE SHALL last exactly one cycle with mem_we=1, mem_addr = word index (first word at 0), mem_wdata = {hi,lo}.
REQ-018 From WRITE, the FSM SHALL return to DATA_HI if words remain; otherwise it SHALL go to CHK (macro on) or DONE (macro off).
REQ-019 in_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK; it SHALL be 0 in WRITE, DONE and ERROR.
REQ-020 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata SHALL hold their last value otherwise.
REQ-021 cpu_rst SHALL be 1 in every state except DONE; in DONE: done=1, cpu_rst=0.
REQ-022 ERROR SHALL set error=1 and keep cpu_rst=1; DONE and ERROR SHALL be left only by rst.
REQ-023 The word counter SHALL be ADDR_W+1 bits so that N = 2^ADDR_W completes without wrap; a write to the last address SHALL be followed by completion, not by a write to address 0.
REQ-024 Gaps in in_valid in any receive state SHALL stall the FSM with no output change.
REQ-025 Bytes presented in DONE or ERROR SHALL be ignored (no transfer).

Reset
REQ-026 While rst=1 at an edge: state=LEN_HI, in_ready=0 (during rst cycle), mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, error=0, counter=0, checksum accumulator=0.
REQ-027 rst asserted mid-load SHALL abandon the load; the next stream SHALL start again from the length header at address 0.

Configuration
REQ-028 With PROG_LOADER_CHECKSUM_EN defined: the accumulator SHALL XOR every transferred length and data byte; in CHK, a transfer equal to the accumulator SHALL go to DONE, and any other value SHALL go to ERROR.
REQ-029 Without PROG_LOADER_CHECKSUM_EN: the CHK state and accumulator SHALL not exist, and no trailing byte SHALL be consumed.

Structure
REQ-030 Package prog_loader_pkg SHALL hold the state enum and the state encodings; no sub-module is used, and the FSM, byte assembler and counter SHALL reside in prog_loader.

Verification
REQ-031 Macro off, stream 00 03 12 34 AB CD 00 01 -> writes (0,1234),(1,ABCD),(2,0001), one mem_we each; done=1 and cpu_rst=0 the cycle after the third write.
REQ-032 Stream 00 00 (macro off) -> no mem_we; DONE is entered on the edge after the LEN_LO transfer.
REQ-033 ADDR_W=8, stream 01 01 -> error=1, cpu_rst stays 1, and later bytes see in_ready=0.
REQ-034 Macro on, stream 00 01 12 34 27 -> done; the same stream with a final byte of 28 -> error, with the single write at address 0 still performed.
REQ-035 The REQ-031 stream with in_valid random gaps, and with rst pulsed after the second write followed by a resend -> identical write sequence starting at address 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - state encodings for the serial program loader.
// CHK exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        WRITE   = 3'd4,
        CHK     = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_e;
`else
    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_e;
`endif

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing words into instruction RAM.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e END_S = CHK;
`else
    localparam state_e END_S = DONE;
`endif

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [15:0]       len_in;
    logic              xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    assign in_ready = !rst && (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO
`ifdef PROG_LOADER_CHECKSUM_EN
                                               , CHK
`endif
                                               });
    assign xfer    = in_valid && in_ready;
    assign len_in  = {len_hi_q, in_data};
    assign idx_nxt = idx_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        hi_d        = hi_q;
        idx_d       = idx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
        if (xfer && state_q != CHK) chk_d = chk_q ^ in_data;
`endif
        case (state_q)
            LEN_HI: if (xfer) begin
                len_hi_d = in_data;
                state_d  = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                len_d = len_in;
                if ({1'b0, len_in} > MAX_WORDS) state_d = ERROR;
                else if (len_in == 16'd0)       state_d = END_S;
                else                            state_d = DATA_HI;
            end
            DATA_HI: if (xfer) begin
                hi_d    = in_data;
                state_d = DATA_LO;
            end
            DATA_LO: if (xfer) begin
                mem_wdata_d = DATA_W'({hi_q, in_data});
                mem_addr_d  = idx_q[ADDR_W-1:0];
                state_d     = WRITE;
            end
            // Counter is one bit wider than the address so a full memory ends cleanly.
            WRITE: begin
                idx_d   = idx_nxt;
                state_d = ({1'b0, len_q} == 17'(idx_nxt)) ? END_S : DATA_HI;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: if (xfer) state_d = (in_data == chk_q) ? DONE : ERROR;
`endif
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
        mem_we_d  = (state_d == WRITE);
        cpu_rst_d = (state_d != DONE);
        done_d    = (state_d == DONE);
        error_d   = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LEN_HI;
            len_hi_q    <= '0;
            len_q       <= '0;
            hi_q        <= '0;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            idx_q       <= idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader (either PROG_LOADER_CHECKSUM_EN setting).
module tb_prog_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    typedef logic [7:0] byte_q_t[$];
    typedef logic [23:0] wr_q_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    int checks = 0;
    int failures = 0;
    wr_q_t wq;

    prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input byte_q_t s);
        logic [7:0] x = 8'h00;
        foreach (s[i]) x ^= s[i];
        return x;
    endfunction

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        wq.delete();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit ok = 0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100; t++) begin
            ok = in_ready;
            @(negedge clk);
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic send_stream(input byte_q_t s, input int maxgap);
        foreach (s[i]) send_byte(s[i], maxgap);
    endtask

    task automatic send_sum(input byte_q_t s);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(xsum(s), 0);
`else
        if (s.size() == 0) @(negedge clk);
`endif
    endtask

    task automatic wait_end();
        for (int t = 0; t < 40 && !(done || error); t++) @(negedge clk);
        settle();
    endtask

    task automatic check_writes(input string tag, input wr_q_t ex);
        chk({tag, "_count"}, wq.size(), ex.size());
        foreach (ex[i]) if (i < wq.size()) chk({tag, "_wr"}, wq[i], ex[i]);
    endtask

    initial begin
        byte_q_t s3, s;
        wr_q_t ex3, ex;
        int bad;
        s3  = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
        ex3 = '{24'h00_1234, 24'h01_ABCD, 24'h02_0001};

        // Basic three-word load with exact completion timing
        do_reset();
        send_stream(s3, 0);
        chk("w3_last_we", mem_we, 1);
        chk("w3_last_addr", mem_addr, 2);
        chk("w3_last_data", mem_wdata, 16'h0001);
`ifdef PROG_LOADER_CHECKSUM_EN
        @(negedge clk);
        chk("w3_chk_ready", in_ready, 1);
        chk("w3_chk_notdone", done, 0);
        send_byte(8'h42, 0);
`else
        @(negedge clk);
`endif
        chk("w3_done", done, 1);
        chk("w3_cpu_rst", cpu_rst, 0);
        chk("w3_we_low", mem_we, 0);
        chk("w3_addr_hold", mem_addr, 2);
        chk("w3_data_hold", mem_wdata, 16'h0001);
        settle();
        check_writes("w3", ex3);

        // Bytes after DONE are not accepted
        in_valid = 1'b1;
        in_data  = 8'h55;
        chk("done_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("done_sticky", done, 1);
        chk("done_no_wr", wq.size(), 3);

        // Zero-length program
        do_reset();
        s = '{8'h00, 8'h00};
        send_stream(s, 0);
`ifndef PROG_LOADER_CHECKSUM_EN
        chk("n0_done_next_edge", done, 1);
`endif
        send_sum(s);
        wait_end();
        chk("n0_done", done, 1);
        chk("n0_no_wr", wq.size(), 0);

        // Oversize length aborts
        do_reset();
        s = '{8'h01, 8'h01};
        send_stream(s, 0);
        chk("big_error", error, 1);
        chk("big_cpu_rst", cpu_rst, 1);
        chk("big_done", done, 0);
        in_valid = 1'b1;
        in_data  = 8'h12;
        repeat (3) begin
            @(negedge clk);
            chk("big_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("big_error_sticky", error, 1);
        chk("big_no_wr", wq.size(), 0);

        // Full memory (N = 256) completes without wrapping to address 0
        do_reset();
        s = '{8'h01, 8'h00};
        ex.delete();
        for (int i = 0; i < 256; i++) begin
            s.push_back(8'(i));
            s.push_back(~8'(i));
            ex.push_back({8'(i), 8'(i), ~8'(i)});
        end
        send_stream(s, 0);
        send_sum(s);
        wait_end();
        repeat (3) @(negedge clk);
        chk("full_done", done, 1);
        chk("full_count", wq.size(), 256);
        bad = 0;
        foreach (ex[i]) if (i >= wq.size() || wq[i] !== ex[i]) bad++;
        chk("full_bad_words", bad, 0);

        // Random in_valid gaps
        do_reset();
        send_stream(s3, 3);
        send_sum(s3);
        wait_end();
        chk("gap_done", done, 1);
        check_writes("gap", ex3);

        // Reset mid-load after the second write, then resend
        do_reset();
        s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_stream(s, 1);
        settle();
        chk("mid_two_writes", wq.size(), 2);
        do_reset();
        send_stream(s3, 2);
        send_sum(s3);
        wait_end();
        chk("resend_done", done, 1);
        check_writes("resend", ex3);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum accept and reject
        do_reset();
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        send_stream(s, 0);
        wait_end();
        chk("ck_good_done", done, 1);
        chk("ck_good_err", error, 0);
        do_reset();
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h28};
        send_stream(s, 0);
        wait_end();
        chk("ck_bad_err", error, 1);
        chk("ck_bad_cpu_rst", cpu_rst, 1);
        check_writes("ck_bad", '{24'h00_1234});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
